fifo_uart_tx: RTL and testbench
===============================

Name: fifo_uart_tx

Overview:
- Serial transmitter that sits directly downstream of the team's synchronous FIFO and drains it.
- Pops one word at a time through the FIFO read port. The FIFO's rd_data is registered and valid one cycle after rd_en.
- Serialises each word onto a UART line: start bit, data LSB first, optional parity, stop bit(s).
- Used as the byte-out stage of the training datapath.

Parameters:
WIDTH, 8, data bits per frame; must equal the upstream FIFO WIDTH.
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2.
PARITY_EN, 0, 1 = insert a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; 1 or 2.

Ports:
clk  input  1  clock; all state on rising edge
rstn  input  1  reset, synchronous, active-low
tx_en  input  1  level enable; new frames start only while high
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  FIFO pop request
fifo_rd_data  input  WIDTH  FIFO read data, valid the cycle after a pop
tx  output  1  serial line, idles high
busy  output  1  high while a fetch or frame is in progress
frame_done  output  1  one-cycle pulse when a frame's last stop bit completes

Behaviour:
- Reset (rstn low at a rising edge): state IDLE, tx=1, busy=0, frame_done=0, baud/bit counters=0, shift register=0. fifo_rd_en=0 throughout reset.
- fifo_rd_en is combinational: (state==IDLE) && tx_en && !fifo_empty && rstn. Never asserted in any other state, so exactly one pop per frame.
- States: IDLE, FETCH, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1, busy=0.
  - If fifo_rd_en is high, go to FETCH; otherwise stay.
  - fifo_empty and tx_en are sampled only in IDLE.
- FETCH (1 cycle):
  - fifo_rd_data is valid; capture it into the shift register.
  - Go to START; busy=1.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - WIDTH bits, LSB first, each held CLKS_PER_BIT cycles.
  - Bit counter counts 0..WIDTH-1; shift on each bit boundary.
- PARITY (only if PARITY_EN=1):
  - Bit value is XOR of all data bits; inverted when PARITY_ODD=1.
  - Held CLKS_PER_BIT cycles.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then go to IDLE.
  - frame_done=1 in the first IDLE cycle only.
- tx, busy and frame_done are registered outputs.
- Latency: tx falls at the second rising edge after the edge that samples fifo_rd_en=1 (IDLE -> FETCH -> START).
- Frame length on the line: (1 + WIDTH + PARITY_EN + STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back frames:
  - Minimum start-to-start spacing is frame length + 2 cycles (one IDLE cycle plus FETCH).
  - tx stays high during that gap.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT), counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - No drift across frames; counter is cleared on entry to START.
- tx_en deasserted mid-frame: the current frame completes unchanged; no further pop afterwards.
- Reset mid-frame:
  - Frame aborts; tx=1 from the reset edge.
  - The popped word is discarded, not re-sent.
- fifo_empty rising while in FETCH..STOP: no effect.

Test Plan:
- WIDTH=8, CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1; push 0xA5, tx_en=1 -> fifo_rd_en high exactly 1 cycle.
  - tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, 40 cycles total.
  - frame_done pulses once; busy high 41 cycles (FETCH + frame).
- PARITY_EN=1: 0xA5 -> parity bit 0 with PARITY_ODD=0, 1 with PARITY_ODD=1; frame 44 cycles. STOP_BITS=2 -> stop high 8 cycles.
- Push 0x00 then 0xFF -> two pops, two frame_done pulses.
  - Line shows start + eight 0s, stop, 2-cycle high gap, then start + eight 1s, stop.
  - Second start falls exactly 42 cycles after the first.
- FIFO empty with tx_en=1 for 100 cycles -> fifo_rd_en never high, tx=1, busy=0.
- tx_en=1 with data present but tx_en dropped during the DATA state -> frame finishes intact, no second pop while tx_en=0. Re-raising tx_en pops the next word.
- rstn low for 1 cycle during the 3rd data bit -> tx=1, busy=0, frame_done=0 after that edge, fifo_rd_en=0 during reset. The next frame sends the following FIFO word, not the aborted one.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a synchronous FIFO with a registered read port.
// It pops one word per frame and sends start, data LSB first, optional parity, then stop bit(s).
module fifo_uart_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             tx_en,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_rd_data,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  state_t            r_state;
  state_t            w_next;
  logic [BAUD_W-1:0] r_baud;
  logic [BIT_W-1:0]  r_bit;
  logic [WIDTH-1:0]  r_shift;
  logic              r_parity;
  logic              r_tx;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_prev_stop;
  logic              w_bit_tick;
  logic              w_line;

  // The pop request is gated by rstn, so a word is never popped during reset.
  assign fifo_rd_en = (r_state == S_IDLE) && tx_en && !fifo_empty && rstn;
  assign w_bit_tick = (r_baud == BAUD_LAST);

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: each output of this block gets a default first, so no path infers a latch.
  always_comb begin
    w_next = r_state;
    w_line = 1'b1;
    unique case (r_state)
      S_IDLE:  if (fifo_rd_en) w_next = S_FETCH;
      S_FETCH: w_next = S_START;
      S_START: begin
        w_line = 1'b0;
        if (w_bit_tick) w_next = S_DATA;
      end
      S_DATA: begin
        w_line = r_shift[0];
        if (w_bit_tick && (r_bit == DATA_LAST))
          w_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_line = r_parity;
        if (w_bit_tick) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_bit_tick && (r_bit == STOP_LAST)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // The outputs are registered from the current state, so they lag the state
  // register by one cycle. frame_done therefore follows the last stop cycle on the line.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_baud       <= '0;
      r_bit        <= '0;
      r_shift      <= '0;
      r_parity     <= 1'b0;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_prev_stop  <= 1'b0;
    end else begin
      r_tx         <= w_line;
      r_busy       <= (r_state != S_IDLE);
      r_prev_stop  <= (r_state == S_STOP);
      r_frame_done <= (r_state == S_IDLE) && r_prev_stop;
      unique case (r_state)
        S_IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
        end
        S_FETCH: begin
          r_shift  <= fifo_rd_data;
          r_parity <= (^fifo_rd_data) ^ (PARITY_ODD != 0);
          r_baud   <= '0;
          r_bit    <= '0;
        end
        default: begin
          r_baud <= w_bit_tick ? '0 : r_baud + 1'b1;
          if (r_state != w_next)
            r_bit <= '0;
          else if (w_bit_tick && ((r_state == S_DATA) || (r_state == S_STOP)))
            r_bit <= r_bit + 1'b1;
          if (w_bit_tick && (r_state == S_DATA))
            r_shift <= r_shift >> 1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three configurations, each fed by a small FIFO model with registered read data.
// The line is sampled on falling edges against hand-computed bit patterns.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int ND  = 3;

  typedef struct {
    int          k;
    logic [7:0]  d;
    logic [15:0] pat;
    int          n;
  } vec_t;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       tx_en   [ND];
  logic       empty   [ND];
  logic       rd_en   [ND];
  logic [7:0] rd_data [ND] = '{default: 8'h00};
  logic       tx      [ND];
  logic       busy    [ND];
  logic       fdone   [ND];

  logic [7:0] mem  [ND][32];
  int         head [ND] = '{default: 0};
  int         tail [ND] = '{default: 0};
  int         pops [ND] = '{default: 0};
  int         dones[ND] = '{default: 0};
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  // dut0: no parity, 1 stop; dut1: even parity, 2 stops; dut2: odd parity, 1 stop.
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rstn(rstn), .tx_en(tx_en[0]), .fifo_empty(empty[0]), .fifo_rd_en(rd_en[0]),
    .fifo_rd_data(rd_data[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(fdone[0]));
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) dut1 (
    .clk(clk), .rstn(rstn), .tx_en(tx_en[1]), .fifo_empty(empty[1]), .fifo_rd_en(rd_en[1]),
    .fifo_rd_data(rd_data[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(fdone[1]));
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rstn(rstn), .tx_en(tx_en[2]), .fifo_empty(empty[2]), .fifo_rd_en(rd_en[2]),
    .fifo_rd_data(rd_data[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(fdone[2]));

  always_comb begin
    for (int k = 0; k < ND; k++) empty[k] = (head[k] == tail[k]);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < ND; k++) begin
      if (rd_en[k]) begin
        rd_data[k] <= mem[k][head[k] % 32];
        head[k]    <= head[k] + 1;
        pops[k]    <= pops[k] + 1;
      end
      if (fdone[k]) dones[k] <= dones[k] + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [7:0] d);
    mem[k][tail[k] % 32] = d;
    tail[k] = tail[k] + 1;
  endtask

  // Waits for the start bit, then checks every cycle of every line bit, followed by the frame_done pulse.
  task automatic run_frame(input int k, input logic [15:0] pat, input int n,
                           input int drop_bit, output int t_start);
    bit   found = 1'b0;
    bit   have_prev = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_tx = 1'b0;
    bit   ok;
    t_start = 0;
    for (int w = 0; w < 40 && !found; w++) begin
      @(negedge clk);
      if (tx[k] === 1'b0) found = 1'b1;
      else begin
        have_prev = 1'b1;
        prev_busy = busy[k];
        prev_tx   = tx[k];
      end
    end
    check($sformatf("dut%0d start_seen", k), 32'(found), 32'd1);
    if (!found) return;
    t_start = cyc;
    if (have_prev) check($sformatf("dut%0d fetch_busy_tx", k), {prev_busy, prev_tx}, 2'b11);
    for (int i = 0; i < n; i++) begin
      ok = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (i == drop_bit && c == 0) tx_en[k] = 1'b0;
        if (tx[k] !== pat[n-1-i] || busy[k] !== 1'b1 || fdone[k] !== 1'b0) ok = 1'b0;
      end
      check($sformatf("dut%0d line_bit%0d", k, i), 32'(ok), 32'd1);
    end
    @(negedge clk);
    check($sformatf("dut%0d done_pulse{fd,busy,tx}", k), {fdone[k], busy[k], tx[k]}, 3'b101);
    @(negedge clk);
    check($sformatf("dut%0d done_low", k), fdone[k], 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt[8];
    int   t1, t2, p0, d0;
    bit   seen_rd, bad_tx, bad_busy, found;

    vt[0] = '{0, 8'hA5, 16'b0101001011,   10};
    vt[1] = '{0, 8'h00, 16'b0000000001,   10};
    vt[2] = '{0, 8'hFF, 16'b0111111111,   10};
    vt[3] = '{0, 8'h3C, 16'b0001111001,   10};
    vt[4] = '{1, 8'hA5, 16'b010100101011, 12};
    vt[5] = '{1, 8'h01, 16'b010000000111, 12};
    vt[6] = '{2, 8'hA5, 16'b01010010111,  11};
    vt[7] = '{2, 8'h80, 16'b00000000101,  11};

    for (int k = 0; k < ND; k++) tx_en[k] = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset {tx,busy,fd,rd_en}", {tx[0], busy[0], fdone[0], rd_en[0]}, 4'b1000);
    rstn = 1'b1;
    @(negedge clk);

    // Single frames from the table.
    for (int v = 0; v < 8; v++) begin
      p0 = pops[vt[v].k];
      d0 = dones[vt[v].k];
      push(vt[v].k, vt[v].d);
      tx_en[vt[v].k] = 1'b1;
      run_frame(vt[v].k, vt[v].pat, vt[v].n, -1, t1);
      check($sformatf("vec%0d pops", v), 32'(pops[vt[v].k] - p0), 32'd1);
      check($sformatf("vec%0d dones", v), 32'(dones[vt[v].k] - d0), 32'd1);
    end

    // Back-to-back: the second start bit falls exactly 42 cycles after the first.
    p0 = pops[0];
    d0 = dones[0];
    push(0, 8'h00);
    push(0, 8'hFF);
    run_frame(0, 16'b0000000001, 10, -1, t1);
    run_frame(0, 16'b0111111111, 10, -1, t2);
    check("b2b spacing", 32'(t2 - t1), 32'd42);
    check("b2b pops", 32'(pops[0] - p0), 32'd2);
    check("b2b dones", 32'(dones[0] - d0), 32'd2);

    // Empty FIFO with tx_en high: the transmitter stays idle.
    seen_rd = 1'b0; bad_tx = 1'b0; bad_busy = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (rd_en[0] !== 1'b0) seen_rd = 1'b1;
      if (tx[0] !== 1'b1) bad_tx = 1'b1;
      if (busy[0] !== 1'b0) bad_busy = 1'b1;
    end
    check("empty rd_en_seen", 32'(seen_rd), 32'd0);
    check("empty tx_not_high", 32'(bad_tx), 32'd0);
    check("empty busy_seen", 32'(bad_busy), 32'd0);

    // tx_en dropped during DATA: the frame completes and no new pop occurs until tx_en returns.
    tx_en[0] = 1'b0;
    push(0, 8'h5A);
    push(0, 8'h11);
    @(negedge clk);
    p0 = pops[0];
    tx_en[0] = 1'b1;
    run_frame(0, 16'b0010110101, 10, 3, t1);
    seen_rd = 1'b0; bad_tx = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (rd_en[0] !== 1'b0) seen_rd = 1'b1;
      if (tx[0] !== 1'b1) bad_tx = 1'b1;
    end
    check("txen_off rd_en_seen", 32'(seen_rd), 32'd0);
    check("txen_off tx_not_high", 32'(bad_tx), 32'd0);
    check("txen_off pops", 32'(pops[0] - p0), 32'd1);
    tx_en[0] = 1'b1;
    run_frame(0, 16'b0100010001, 10, -1, t1);
    check("txen_on pops", 32'(pops[0] - p0), 32'd2);

    // Reset during the third data bit: the popped word is discarded and the next word is sent.
    tx_en[0] = 1'b0;
    push(0, 8'hC3);
    push(0, 8'h81);
    @(negedge clk);
    p0 = pops[0];
    d0 = dones[0];
    tx_en[0] = 1'b1;
    found = 1'b0;
    for (int w = 0; w < 40 && !found; w++) begin
      @(negedge clk);
      if (tx[0] === 1'b0) found = 1'b1;
    end
    check("abort start_seen", 32'(found), 32'd1);
    repeat (13) @(negedge clk);
    check("abort data_bit2", tx[0], 1'b0);
    rstn = 1'b0;
    @(negedge clk);
    check("abort {tx,busy,fd,rd_en}", {tx[0], busy[0], fdone[0], rd_en[0]}, 4'b1000);
    rstn = 1'b1;
    run_frame(0, 16'b0100000011, 10, -1, t1);
    check("abort pops", 32'(pops[0] - p0), 32'd2);
    check("abort dones", 32'(dones[0] - d0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
